mtsp_bus_responder: RTL and testbench
=====================================

Name: mtsp_bus_responder

Overview:
- Target-side responder for the MTSP master bus.
- Accepts burst read/write requests from the MTSP bus-master controller and services them against a single-port synchronous SRAM backing store, one 256-bit beat per transfer.
- Serves as the memory-side end of the master interface in system-level simulation and FPGA builds. Provides backpressure and in-order read return with a 2-entry output buffer.

Parameters:
- ADDR_WIDTH, 32, byte address width of request.
- DATA_WIDTH, 256, beat width (DWORDx8).
- MEM_AW, 10, SRAM beat-index width (depth = 2^MEM_AW beats).
- LEN_WIDTH, 4, burst length field width (beats = LEN+1, max 16).

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, asynchronous, active-high
- REQ_VALID  in  1  request valid
- REQ_READY  out  1  request accepted when VALID&READY
- REQ_WRITE  in  1  1 = write burst, 0 = read burst
- REQ_ADDR  in  ADDR_WIDTH  byte start address
- REQ_LEN  in  LEN_WIDTH  beats minus one
- W_VALID  in  1  write beat valid
- W_READY  out  1  write beat accepted
- W_DATA  in  DATA_WIDTH  write beat
- R_VALID  out  1  read beat valid
- R_READY  in  1  read beat consumed
- R_DATA  out  DATA_WIDTH  read beat
- R_LAST  out  1  final beat of read burst
- W_DONE  out  1  one-cycle pulse: write burst fully committed
- BUSY  out  1  burst in progress or read data pending
- MEM_EN  out  1  SRAM access enable
- MEM_WE  out  1  SRAM write enable
- MEM_ADDR  out  MEM_AW  SRAM beat index
- MEM_WDATA  out  DATA_WIDTH  SRAM write data
- MEM_RDATA  in  DATA_WIDTH  SRAM read data, valid 1 cycle after read MEM_EN

Behaviour:
- Reset (RST=1, asynchronous):
  - FSM returns to IDLE and the output buffer is emptied.
  - All outputs are 0 except REQ_READY=1 after reset deasserts.
  - Reset mid-burst abandons the burst: no W_DONE, and buffered read data is discarded.
- Address mapping:
  - Beat index = REQ_ADDR[5+MEM_AW-1:5]; REQ_ADDR[4:0] is ignored.
  - The index increments by 1 per beat and wraps modulo 2^MEM_AW (for example, 0x3FF -> 0x000).
- FSM states: IDLE, WRITE, READ, DRAIN.
  - IDLE:
    - REQ_READY=1.
    - On handshake, latch the index and the beat counter = REQ_LEN.
    - Go to WRITE if REQ_WRITE, otherwise READ.
  - WRITE:
    - W_READY=1.
    - On each W_VALID&W_READY: MEM_EN=MEM_WE=1 in the same cycle (combinational), MEM_ADDR=index, MEM_WDATA=W_DATA. Then increment the index and decrement the counter.
    - On the beat with counter==0, go to IDLE and pulse W_DONE in the next cycle.
    - W_VALID gaps are allowed; W_READY=0 outside WRITE.
  - READ:
    - Issue an SRAM read (MEM_EN=1, MEM_WE=0) in any cycle where buffer occupancy plus in-flight reads < 2.
    - Data captured from MEM_RDATA the next cycle enters the 2-entry FIFO, tagged last if its counter was 0.
    - After the last read is issued, go to DRAIN.
  - DRAIN: return to IDLE when the FIFO is empty and nothing is in flight.
- Read latency:
  - Request accepted at cycle T, first MEM_EN at T+1, first R_VALID at T+2.
  - With R_READY held at 1, throughput is 1 beat per cycle.
- Read backpressure:
  - R_DATA and R_LAST are stable while R_VALID=1 and R_READY=0.
  - The buffer never overflows because the credit check above counts in-flight reads.
- Simultaneous FIFO push and pop in the same cycle keeps occupancy constant.
- R_LAST=1 only with the final beat of a burst.
- REQ_READY=0 in all states other than IDLE; there are no outstanding/overlapping bursts.
- BUSY = (state != IDLE) | FIFO not empty | read in flight.
- A W_VALID beat arriving in IDLE is held off (W_READY=0) until the matching write request is accepted.

Test Plan:
- Single write: REQ_WRITE=1, ADDR=0x40, LEN=0, one W_DATA=0xA5..A5 -> MEM_WE at index 2 in the W handshake cycle; W_DONE pulses 1 cycle later; REQ_READY back to 1.
- Write then read: write 4 beats at 0x1000 (data k=0..3), then read LEN=3 with R_READY=1 -> R_VALID at T+2, four consecutive beats 0..3, R_LAST on the 4th only.
- Read backpressure: read LEN=7 with R_READY toggling 1,0,0,1... -> no lost or duplicated beats; R_DATA stable while stalled; at most 2 reads outstanding (occupancy + in-flight ≤ 2).
- Wrap-around: MEM_AW=10, write LEN=2 at ADDR=0x7FE0 (index 0x3FF) -> MEM_ADDR sequence 0x3FF, 0x000, 0x001; readback matches.
- Write with gaps: W_VALID pattern 1,0,1,0,1 for LEN=2 -> exactly 3 SRAM writes; W_DONE only after the 3rd beat.
- Reset mid-read: assert RST during beat 2 of a LEN=7 read -> R_VALID=0 and BUSY=0 immediately; after release REQ_READY=1, and a new read returns correct data with no stale beats.

Source files
------------

// File: rtl/mtsp_bus_responder.sv
// Target-side responder for the MTSP master bus: services burst reads and writes
// against a single-port synchronous SRAM, returning read beats through a 2-entry buffer.
`timescale 1ns/1ps
module mtsp_bus_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int MEM_AW     = 10,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [LEN_WIDTH-1:0]  REQ_LEN,
    input  logic                  W_VALID,
    output logic                  W_READY,
    input  logic [DATA_WIDTH-1:0] W_DATA,
    output logic                  R_VALID,
    input  logic                  R_READY,
    output logic [DATA_WIDTH-1:0] R_DATA,
    output logic                  R_LAST,
    output logic                  W_DONE,
    output logic                  BUSY,
    output logic                  MEM_EN,
    output logic                  MEM_WE,
    output logic [MEM_AW-1:0]     MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_WDATA,
    input  logic [DATA_WIDTH-1:0] MEM_RDATA,
    output logic [1:0]            dbg_state
);

    // Handshakes: a transfer on REQ, W or R happens in a cycle where VALID and
    // READY are both 1 at the rising edge; VALID never waits on READY.
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    state_t                 state;
    logic [MEM_AW-1:0]      idx;
    logic [LEN_WIDTH-1:0]   cnt;
    logic                   inflight;
    logic                   inflight_last;
    logic [DATA_WIDTH-1:0]  fifo_data [2];
    logic [1:0]             fifo_last;
    logic                   rd_ptr;
    logic                   wr_ptr;
    logic [1:0]             occ;
    logic                   w_done_q;

    logic w_fire;
    logic rd_issue;
    logic fifo_push;
    logic fifo_pop;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{REQ_ADDR[4:0], REQ_ADDR[ADDR_WIDTH-1:5+MEM_AW]};

    assign w_fire   = (state == S_WRITE) && W_VALID;
    // Credit counts in-flight reads so the 2-entry buffer can never overflow.
    assign rd_issue = (state == S_READ) && ((occ + {1'b0, inflight}) < 2'd2);
    assign fifo_pop = (occ != 2'd0) && R_READY;
    // An empty buffer lets returning SRAM data go straight out; it is only stored if not taken.
    assign fifo_push = inflight && !((occ == 2'd0) && R_READY);

    assign REQ_READY = (state == S_IDLE) && !RST;
    assign W_READY   = (state == S_WRITE);
    assign MEM_EN    = w_fire || rd_issue;
    assign MEM_WE    = w_fire;
    assign MEM_ADDR  = MEM_EN ? idx : '0;
    assign MEM_WDATA = w_fire ? W_DATA : '0;
    assign R_VALID   = (occ != 2'd0) || inflight;
    assign R_DATA    = (occ != 2'd0) ? fifo_data[rd_ptr] : (inflight ? MEM_RDATA : '0);
    assign R_LAST    = (occ != 2'd0) ? fifo_last[rd_ptr] : (inflight && inflight_last);
    assign W_DONE    = w_done_q;
    assign BUSY      = (state != S_IDLE) || (occ != 2'd0) || inflight;
    assign dbg_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= S_IDLE;
            idx           <= '0;
            cnt           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_last     <= '0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            occ           <= '0;
            w_done_q      <= 1'b0;
        end else begin
            w_done_q      <= 1'b0;
            inflight      <= rd_issue;
            inflight_last <= rd_issue && (cnt == '0);

            if (fifo_push) begin
                fifo_data[wr_ptr] <= MEM_RDATA;
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (fifo_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            case (state)
                S_IDLE: begin
                    if (REQ_VALID) begin
                        idx   <= REQ_ADDR[5 +: MEM_AW];
                        cnt   <= REQ_LEN;
                        state <= REQ_WRITE ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    if (w_fire) begin
                        idx <= idx + MEM_AW'(1);
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (cnt == '0) begin
                            state    <= S_IDLE;
                            w_done_q <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (rd_issue) begin
                        idx <= idx + MEM_AW'(1);
                        cnt <= cnt - LEN_WIDTH'(1);
                        if (cnt == '0) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if ((occ == 2'd0) && !inflight) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtsp_bus_responder.sv
// Directed bench for mtsp_bus_responder: SRAM model, write/read burst drivers,
// expected-queue scoreboard for read beats.
`timescale 1ns/1ps
module tb_mtsp_bus_responder;

    logic         CLK = 1'b0;
    logic         RST;
    logic         REQ_VALID, REQ_READY, REQ_WRITE;
    logic [31:0]  REQ_ADDR;
    logic [3:0]   REQ_LEN;
    logic         W_VALID, W_READY;
    logic [255:0] W_DATA;
    logic         R_VALID, R_READY, R_LAST;
    logic [255:0] R_DATA;
    logic         W_DONE, BUSY, MEM_EN, MEM_WE;
    logic [9:0]   MEM_ADDR;
    logic [255:0] MEM_WDATA, MEM_RDATA;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errs   = 0;
    int wr_cnt   = 0;
    int rd_iss   = 0;
    logic [255:0] exp_q[$];
    logic [255:0] mem [1024];

    localparam logic [255:0] D_A5   = {32{8'hA5}};
    localparam logic [255:0] D_BP   = {64'hBEEF_0000_1234_5678, 192'h0};
    localparam logic [255:0] D_WRAP = {128'h0, 128'h7777_0000_0000_0000_0000_0000_0000_0100};
    localparam logic [255:0] D_GAP  = {32'h6A6A_0000, 224'h10};

    mtsp_bus_responder dut (
        .CLK(CLK), .RST(RST),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
        .REQ_ADDR(REQ_ADDR), .REQ_LEN(REQ_LEN),
        .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
        .R_VALID(R_VALID), .R_READY(R_READY), .R_DATA(R_DATA), .R_LAST(R_LAST),
        .W_DONE(W_DONE), .BUSY(BUSY),
        .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
        .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
        .dbg_state(dbg_state)
    );

    // clock / reset-independent SRAM model
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (MEM_EN) begin
            if (MEM_WE) begin
                mem[MEM_ADDR] <= MEM_WDATA;
                wr_cnt        <= wr_cnt + 1;
            end else begin
                MEM_RDATA <= mem[MEM_ADDR];
                rd_iss    <= rd_iss + 1;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] len,
                            input logic [255:0] base, input bit gaps);
        logic [9:0] widx;
        int w0;
        widx = addr[14:5];
        w0   = wr_cnt;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b1; REQ_ADDR = addr; REQ_LEN = len;
        W_VALID = 1'b1; W_DATA = base;
        @(negedge CLK);
        check("wr_req_ready", REQ_READY, 1);
        check("w_held_in_idle", W_READY, 0);
        check("no_mem_in_idle", MEM_EN, 0);
        step();
        REQ_VALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            if (gaps && k > 0) begin
                W_VALID = 1'b0;
                @(negedge CLK);
                check("gap_no_write", MEM_EN, 0);
                check("gap_no_done", W_DONE, 0);
                check("gap_busy", BUSY, 1);
                step();
            end
            W_VALID = 1'b1;
            W_DATA  = base + k;
            @(negedge CLK);
            check("w_ready", W_READY, 1);
            check("wr_mem_we", MEM_WE, 1);
            check("wr_mem_en", MEM_EN, 1);
            check("wr_mem_addr", MEM_ADDR, widx);
            check("wr_mem_wdata", MEM_WDATA, base + k);
            check("wr_no_early_done", W_DONE, 0);
            widx++;
            step();
        end
        W_VALID = 1'b0;
        @(negedge CLK);
        check("w_done_pulse", W_DONE, 1);
        check("wr_back_idle", REQ_READY, 1);
        check("w_ready_off", W_READY, 0);
        check("wr_count", wr_cnt - w0, int'(len) + 1);
        step();
        @(negedge CLK);
        check("w_done_one_cycle", W_DONE, 0);
        step();
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] len,
                           input bit toggle, input int stop_after);
        logic [9:0]   ridx;
        logic [255:0] held_d, e;
        logic         held_l;
        int           iss0, consumed;
        bit           stall;
        ridx = addr[14:5];
        iss0 = rd_iss;
        consumed = 0;
        stall = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        REQ_VALID = 1'b1; REQ_WRITE = 1'b0; REQ_ADDR = addr; REQ_LEN = len; R_READY = 1'b0;
        @(negedge CLK);
        check("rd_req_ready", REQ_READY, 1);
        check("rd_no_mem_t0", MEM_EN, 0);
        step();
        REQ_VALID = 1'b0;
        R_READY   = 1'b1;
        @(negedge CLK);
        check("rvalid_t1", R_VALID, 0);
        check("first_issue_t1", MEM_EN, 1);
        if (MEM_EN) begin
            check("rd_not_we", MEM_WE, 0);
            check("rd_addr", MEM_ADDR, ridx);
            ridx++;
        end
        step();
        for (int cyc = 0; cyc < 100 && exp_q.size() > 0; cyc++) begin
            R_READY = toggle ? (cyc % 3 == 0) : 1'b1;
            @(negedge CLK);
            if (MEM_EN) begin
                check("rd_not_we", MEM_WE, 0);
                check("rd_addr", MEM_ADDR, ridx);
                ridx++;
            end
            check("outstanding_le2", ((rd_iss - iss0) + int'(MEM_EN) - consumed) <= 2, 1);
            if (cyc == 0) check("rvalid_t2", R_VALID, 1);
            if (!toggle) check("rvalid_stream", R_VALID, 1);
            if (stall) begin
                check("stall_valid", R_VALID, 1);
                check("stall_data", R_DATA, held_d);
                check("stall_last", R_LAST, held_l);
            end
            stall  = R_VALID && !R_READY;
            held_d = R_DATA;
            held_l = R_LAST;
            if (R_VALID && R_READY) begin
                e = exp_q.pop_front();
                check("rd_data", R_DATA, e);
                check("rd_last", R_LAST, exp_q.size() == 0);
                consumed++;
                if (consumed == stop_after) return;
            end
            step();
        end
        check("rd_complete", exp_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            if (REQ_READY) break;
            step();
        end
        check("rd_back_idle", REQ_READY, 1);
        check("rd_not_busy", BUSY, 0);
        check("rd_no_extra_valid", R_VALID, 0);
        check("rd_issue_count", rd_iss - iss0, int'(len) + 1);
        step();
    endtask

    initial begin
        RST = 1'b1;
        REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0; REQ_LEN = '0;
        W_VALID = 1'b0; W_DATA = '0; R_READY = 1'b0;

        @(negedge CLK);
        check("rst_req_ready", REQ_READY, 0);
        check("rst_busy", BUSY, 0);
        check("rst_rvalid", R_VALID, 0);
        check("rst_wready", W_READY, 0);
        check("rst_wdone", W_DONE, 0);
        check("rst_mem_en", MEM_EN, 0);
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("post_rst_req_ready", REQ_READY, 1);
        check("post_rst_state", dbg_state, 0);
        step();

        // single beat write at index 2
        do_write(32'h0000_0040, 4'd0, D_A5, 1'b0);

        // 4-beat write then streaming read
        do_write(32'h0000_1000, 4'd3, 256'h0, 1'b0);
        for (int k = 0; k < 4; k++) exp_q.push_back(256'(k));
        do_read(32'h0000_1000, 4'd3, 1'b0, -1);

        // 8-beat burst read under R_READY backpressure
        do_write(32'h0000_2000, 4'd7, D_BP, 1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back(D_BP + k);
        do_read(32'h0000_2000, 4'd7, 1'b1, -1);

        // index wrap 0x3FF -> 0x000 -> 0x001
        do_write(32'h0000_7FE0, 4'd2, D_WRAP, 1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back(D_WRAP + k);
        do_read(32'h0000_7FE0, 4'd2, 1'b0, -1);

        // W_VALID pattern 1,0,1,0,1
        do_write(32'h0000_3000, 4'd2, D_GAP, 1'b1);
        for (int k = 0; k < 3; k++) exp_q.push_back(D_GAP + k);
        do_read(32'h0000_3000, 4'd2, 1'b1, -1);

        // reset in the middle of a long read
        for (int k = 0; k < 8; k++) exp_q.push_back(D_BP + k);
        do_read(32'h0000_2000, 4'd7, 1'b0, 2);
        #2 RST = 1'b1;
        #1;
        check("midrst_rvalid", R_VALID, 0);
        check("midrst_busy", BUSY, 0);
        check("midrst_mem_en", MEM_EN, 0);
        exp_q.delete();
        R_READY = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("midrst_req_ready", REQ_READY, 1);
        check("midrst_no_stale", R_VALID, 0);
        check("midrst_no_done", W_DONE, 0);
        step();
        for (int k = 0; k < 4; k++) exp_q.push_back(256'(k));
        do_read(32'h0000_1000, 4'd3, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
